// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Selects one of up to four test programs, pulses the core's
//                PC load with the program entry address, enables execution
//                and watches for the completion address, a cycle timeout or
//                a request abort. The result is reported with ack and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer #(
    parameter int                 PC_BITS        = 10,
    parameter int                 NUM_PROGS      = 3,
    parameter logic [PC_BITS-1:0] START_ADDRS [4] = '{PC_BITS'(0),   PC_BITS'(436),
                                                      PC_BITS'(15),  PC_BITS'(0)},
    parameter logic [PC_BITS-1:0] DONE_ADDRS  [4] = '{PC_BITS'(435), PC_BITS'(15),
                                                      PC_BITS'(30),  PC_BITS'(0)},
    parameter int                 TIMEOUT_CYCLES = 65535
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req,
    input  logic [1:0]         prog_sel,
    input  logic [PC_BITS-1:0] pc,
    output logic               start,
    output logic [PC_BITS-1:0] start_addr,
    output logic               run_en,
    output logic               ack,
    output logic               busy,
    output logic [1:0]         status,
    output logic [15:0]        cycle_count
);

    localparam logic [1:0]  c_st_ok      = 2'b00;
    localparam logic [1:0]  c_st_timeout = 2'b01;
    localparam logic [1:0]  c_st_badsel  = 2'b10;
    localparam logic [1:0]  c_st_abort   = 2'b11;
    localparam logic [15:0] c_timeout    = 16'(TIMEOUT_CYCLES);
    localparam logic [2:0]  c_num_progs  = 3'(NUM_PROGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic               r_start;
    logic [PC_BITS-1:0] r_start_addr;
    logic               r_run_en;
    logic               r_ack;
    logic               r_busy;
    logic [1:0]         r_status;
    logic [15:0]        r_cycle_count;

    logic               w_sel_ok;
    logic               w_done_hit;
    logic [15:0]        w_cc_next;

    // Request validity, completion match and the prospective count value
    assign w_sel_ok   = ({1'b0, prog_sel} < c_num_progs);
    assign w_done_hit = (pc == DONE_ADDRS[r_sel]);
    assign w_cc_next  = r_cycle_count + 16'd1;

    // Sequencer FSM; every output is a register updated alongside the state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sel         <= 2'd0;
            r_start       <= 1'b0;
            r_start_addr  <= '0;
            r_run_en      <= 1'b0;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_status      <= c_st_ok;
            r_cycle_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (w_sel_ok) begin
                            r_sel         <= prog_sel;
                            r_start       <= 1'b1;
                            r_start_addr  <= START_ADDRS[prog_sel];
                            r_cycle_count <= 16'd0;
                            r_status      <= c_st_ok;
                            r_busy        <= 1'b1;
                            r_state       <= S_LOAD;
                        end else begin
                            r_status <= c_st_badsel;
                            r_ack    <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    r_start  <= 1'b0;
                    r_run_en <= 1'b1;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    // Abort beats completion, completion beats timeout
                    if (!req) begin
                        r_status <= c_st_abort;
                        r_run_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_done_hit) begin
                        r_status <= c_st_ok;
                        r_run_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cycle_count <= w_cc_next;
                        if (w_cc_next == c_timeout) begin
                            r_status <= c_st_timeout;
                            r_run_en <= 1'b0;
                            r_busy   <= 1'b0;
                            r_ack    <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Leaving DONE needs req low, so IDLE always sees a fresh request
                    if (!req) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start       = r_start;
    assign start_addr  = r_start_addr;
    assign run_en      = r_run_en;
    assign ack         = r_ack;
    assign busy        = r_busy;
    assign status      = r_status;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_sequencer
//  Description : Self-checking bench for program_sequencer. Two instances with
//                different timeouts share stimulus; a behavioural model
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;
    localparam int NPROGS  = 3;
    localparam int START_T [3] = '{0, 436, 15};
    localparam int DONE_T  [3] = '{435, 15, 30};
    localparam int TMO     [2] = '{20, 8};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  prog_sel = 2'd0;
    logic [9:0]  pc = 10'd0;

    logic        start_o [2];
    logic [9:0]  saddr_o [2];
    logic        run_en_o [2];
    logic        ack_o [2];
    logic        busy_o [2];
    logic [1:0]  status_o [2];
    logic [15:0] cc_o [2];

    int n_chk = 0;
    int n_fail = 0;
    int n_start0 = 0;
    bit chk_en = 1'b0;

    int pc_mode = 0;
    logic [9:0] pc_fix = 10'd0;
    int core_pc = 0;

    int m_ph [2];
    int m_sel [2];
    int m_saddr [2];
    int m_st [2];
    int m_cc [2];

    program_sequencer #(.TIMEOUT_CYCLES(20)) u_dut0 (
        .clock(clock), .reset(reset), .req(req), .prog_sel(prog_sel), .pc(pc),
        .start(start_o[0]), .start_addr(saddr_o[0]), .run_en(run_en_o[0]),
        .ack(ack_o[0]), .busy(busy_o[0]), .status(status_o[0]), .cycle_count(cc_o[0])
    );

    program_sequencer #(.TIMEOUT_CYCLES(8)) u_dut1 (
        .clock(clock), .reset(reset), .req(req), .prog_sel(prog_sel), .pc(pc),
        .start(start_o[1]), .start_addr(saddr_o[1]), .run_en(run_en_o[1]),
        .ack(ack_o[1]), .busy(busy_o[1]), .status(status_o[1]), .cycle_count(cc_o[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One run-level step of the reference: what the sequencer must do this edge
    task automatic model_step(input int i);
        int idx;
        idx = int'(prog_sel);
        if (reset) begin
            m_ph[i] = PH_IDLE; m_sel[i] = 0; m_saddr[i] = 0; m_st[i] = 0; m_cc[i] = 0;
        end else if (m_ph[i] == PH_IDLE) begin
            if (req && idx < NPROGS) begin
                m_sel[i] = idx; m_saddr[i] = START_T[idx]; m_cc[i] = 0; m_st[i] = 0;
                m_ph[i] = PH_LOAD;
            end else if (req) begin
                m_st[i] = 2; m_ph[i] = PH_DONE;
            end
        end else if (m_ph[i] == PH_LOAD) begin
            m_ph[i] = PH_RUN;
        end else if (m_ph[i] == PH_RUN) begin
            if (!req) begin
                m_st[i] = 3; m_ph[i] = PH_IDLE;
            end else if (int'(pc) == DONE_T[m_sel[i]]) begin
                m_st[i] = 0; m_ph[i] = PH_DONE;
            end else begin
                m_cc[i] = m_cc[i] + 1;
                if (m_cc[i] == TMO[i]) begin
                    m_st[i] = 1; m_ph[i] = PH_DONE;
                end
            end
        end else if (!req) begin
            m_ph[i] = PH_IDLE;
        end
    endtask

    // Core PC model (follows instance 0's expected controls) and reference update
    always @(posedge clock) begin
        if (m_ph[0] == PH_LOAD) core_pc = m_saddr[0];
        else if (m_ph[0] == PH_RUN) core_pc = (core_pc + 1) % 1024;
        for (int i = 0; i < 2; i++) model_step(i);
        if (reset) chk_en = 1'b1;
    end

    // PC driver: stepping core, a fixed value, or random/done-address jumps
    always @(posedge clock) begin
        int r;
        #3;
        if (pc_mode == 0) pc = 10'(core_pc);
        else if (pc_mode == 1) pc = pc_fix;
        else begin
            r = int'($urandom % 3);
            if ($urandom % 3 == 0) pc = 10'(DONE_T[r]);
            else pc = 10'($urandom % 1024);
        end
    end

    // Per-cycle comparison of both instances against the reference
    always @(negedge clock) begin
        if (chk_en) begin
            if (start_o[0]) n_start0++;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("start%0d", i),  int'(start_o[i]),  int'(m_ph[i] == PH_LOAD));
                chk($sformatf("run_en%0d", i), int'(run_en_o[i]), int'(m_ph[i] == PH_RUN));
                chk($sformatf("busy%0d", i),   int'(busy_o[i]),
                    int'(m_ph[i] == PH_LOAD || m_ph[i] == PH_RUN));
                chk($sformatf("ack%0d", i),    int'(ack_o[i]),    int'(m_ph[i] == PH_DONE));
                chk($sformatf("saddr%0d", i),  int'(saddr_o[i]),  m_saddr[i]);
                chk($sformatf("status%0d", i), int'(status_o[i]), m_st[i]);
                chk($sformatf("cc%0d", i),     int'(cc_o[i]),     m_cc[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_ack(input int inst, input int maxc, output int waited);
        waited = 0;
        for (int k = 1; k <= maxc; k++) begin
            cyc(1);
            if (ack_o[inst]) begin
                waited = k;
                break;
            end
        end
        if (waited == 0) chk($sformatf("ack_wait%0d", inst), 0, 1);
    endtask

    initial begin
        int w;
        int s0;
        cyc(3);
        reset = 1'b0;

        // Program 2 with a stepping PC 15..30
        req = 1'b1; prog_sel = 2'd2;
        cyc(1);
        chk("p2_start", int'(start_o[0]), 1);
        chk("p2_saddr", int'(saddr_o[0]), 15);
        chk("p2_cc0",   int'(cc_o[0]), 0);
        cyc(1);
        chk("p2_start_off", int'(start_o[0]), 0);
        chk("p2_run_en",    int'(run_en_o[0]), 1);
        wait_ack(0, 40, w);
        chk("p2_cc",     int'(cc_o[0]), 15);
        chk("p2_status", int'(status_o[0]), 0);
        chk("p2_model",  m_cc[0], 15);
        chk("p2_t8_cc",     int'(cc_o[1]), 8);
        chk("p2_t8_status", int'(status_o[1]), 1);

        // Holding req after ack never restarts; a one-cycle low does
        s0 = n_start0;
        cyc(10);
        chk("hold_nostart", n_start0 - s0, 0);
        chk("hold_ack",     int'(ack_o[0]), 1);
        req = 1'b0;
        cyc(1);
        chk("drop_ack", int'(ack_o[0]), 0);
        req = 1'b1;
        cyc(1);
        chk("restart", int'(start_o[0]), 1);

        // Abort after five RUN cycles
        cyc(1);
        cyc(5);
        req = 1'b0;
        cyc(1);
        chk("abort_status", int'(status_o[0]), 3);
        chk("abort_ack",    int'(ack_o[0]), 0);
        chk("abort_cc",     int'(cc_o[0]), 5);
        cyc(1);
        chk("abort_cc_hold", int'(cc_o[0]), 5);

        // Invalid program select
        s0 = n_start0;
        prog_sel = 2'd3; req = 1'b1;
        cyc(1);
        chk("bad_ack",    int'(ack_o[0]), 1);
        chk("bad_status", int'(status_o[0]), 2);
        cyc(2);
        chk("bad_nostart", n_start0 - s0, 0);
        req = 1'b0;
        cyc(1);

        // Timeout with PC stuck at 0 on program 0
        pc_mode = 1; pc_fix = 10'd0;
        cyc(1);
        prog_sel = 2'd0; req = 1'b1;
        wait_ack(1, 20, w);
        chk("tmo8_latency", w, 10);
        chk("tmo8_cc",      int'(cc_o[1]), 8);
        chk("tmo8_status",  int'(status_o[1]), 1);
        wait_ack(0, 30, w);
        chk("tmo20_cc",     int'(cc_o[0]), 20);
        req = 1'b0;
        cyc(1);
        pc_mode = 0;

        // Reset during RUN cycle 3 with req held high
        prog_sel = 2'd2; req = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        chk("rst_run_en", int'(run_en_o[0]), 0);
        chk("rst_busy",   int'(busy_o[0]), 0);
        chk("rst_saddr",  int'(saddr_o[0]), 0);
        chk("rst_cc",     int'(cc_o[0]), 0);
        reset = 1'b0;
        cyc(1);
        chk("rst_reload", int'(start_o[0]), 1);
        wait_ack(0, 40, w);
        req = 1'b0;
        cyc(2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom % 100) < 2;
            if ($urandom % 14 == 0) req = ~req;
            prog_sel = 2'($urandom % 4);
            pc_mode = ($urandom % 4 == 0) ? 2 : 0;
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
